// File: rtl/fft_pkg.sv
// Shared defaults and FSM encoding for the FFT spectrum reader.
// No logic of its own; latency not applicable.
// No flow control of its own; backpressure not applicable.
package fft_pkg;

    localparam int FFT_ADDR_WIDTH = 8;
    localparam int FFT_DATA_WIDTH = 12;
    localparam int FFT_NUM_BINS   = 128;

    // Frame sequencing states of the reader
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/spectrum_skid_fifo.sv
// Two-entry synchronous FIFO holding {last, bin, height} beats for the reader output.
// Latency: a pushed beat is visible at the head on the cycle after the push.
// Backpressure: head holds while out_rdy is low; the caller keeps pushes within the free space.
module spectrum_skid_fifo #(
    parameter int BIN_WIDTH    = 8,
    parameter int HEIGHT_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_vld,
    input  logic                    in_last,
    input  logic [BIN_WIDTH-1:0]    in_bin,
    input  logic [HEIGHT_WIDTH-1:0] in_height,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic                    out_last,
    output logic [BIN_WIDTH-1:0]    out_bin,
    output logic [HEIGHT_WIDTH-1:0] out_height,
    output logic [1:0]              count
);

    localparam int W = 1 + BIN_WIDTH + HEIGHT_WIDTH;

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_ptr_q, wr_ptr_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         pop;
    logic         push_ok;

    assign pop     = out_vld && out_rdy;
    // A push into a full FIFO is only legal when the head leaves in the same cycle
    assign push_ok = in_vld && ((count_q != 2'd2) || pop);

    // Next-state for storage, pointers and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + 2'(push_ok) - 2'(pop);
        if (push_ok) begin
            mem_d[wr_ptr_q] = {in_last, in_bin, in_height};
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign {out_last, out_bin, out_height} = mem_q[rd_ptr_q];
    assign out_vld = (count_q != 2'd0);
    assign count   = count_q;

endmodule

// File: rtl/fft_spectrum_reader.sv
// Sweeps the FFT magnitude RAM per fft_done, streams scaled bar heights and tracks the per-frame peak.
// Latency: first m_valid two clock edges after the edge that samples fft_done; 1 beat/cycle sustained.
// Backpressure: RAM reads are throttled so FIFO entries plus the in-flight read never exceed two.
module fft_spectrum_reader
    import fft_pkg::*;
#(
    parameter int ADDR_WIDTH   = FFT_ADDR_WIDTH,
    parameter int DATA_WIDTH   = FFT_DATA_WIDTH,
    parameter int NUM_BINS     = FFT_NUM_BINS,
    parameter int HEIGHT_WIDTH = 10,
    parameter int HEIGHT_MAX   = 600,
    parameter int SCALE_SHIFT  = 1,
    parameter int EXCLUDE_DC   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    fft_done,
    output logic [ADDR_WIDTH-1:0]   fft_addr_out,
    output logic                    fft_data_out_en,
    input  logic [DATA_WIDTH-1:0]   fft_data_out,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [ADDR_WIDTH-1:0]   m_bin,
    output logic [HEIGHT_WIDTH-1:0] m_height,
    output logic                    m_last,
    output logic                    busy,
    output logic [ADDR_WIDTH-1:0]   peak_bin,
    output logic [DATA_WIDTH-1:0]   peak_val,
    output logic [15:0]             frame_cnt
);

    localparam logic [ADDR_WIDTH-1:0] LAST_BIN = ADDR_WIDTH'(NUM_BINS - 1);

    rd_state_t              state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic                   inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0]  rd_bin_q, rd_bin_d;
    logic                   pending_q, pending_d;
    logic [DATA_WIDTH-1:0]  max_val_q, max_val_d;
    logic [ADDR_WIDTH-1:0]  max_bin_q, max_bin_d;
    logic [ADDR_WIDTH-1:0]  peak_bin_q, peak_bin_d;
    logic [DATA_WIDTH-1:0]  peak_val_q, peak_val_d;
    logic [15:0]            frame_cnt_q, frame_cnt_d;

    logic                    rd_issue;
    logic                    frame_start;
    logic [1:0]              fifo_count;
    logic                    fifo_pop;
    logic [1:0]              outstanding;
    logic                    credit_ok;
    logic [31:0]             mag_scaled;
    logic [HEIGHT_WIDTH-1:0] height;
    logic                    dc_skip;

    assign fifo_pop = m_valid && m_ready;

    // The head leaving this cycle frees its slot, so the read loop sustains one beat per cycle
    assign outstanding = fifo_count - 2'(fifo_pop) + 2'(inflight_q);
    assign credit_ok   = (outstanding < 2'd2);

    assign dc_skip = (EXCLUDE_DC != 0) && (rd_bin_q == '0);

    // Scale the returned magnitude and clamp it to the bar ceiling
    always_comb begin
        mag_scaled = 32'(fft_data_out) >> SCALE_SHIFT;
        if (mag_scaled > 32'(HEIGHT_MAX)) begin
            height = HEIGHT_WIDTH'(HEIGHT_MAX);
        end else begin
            height = HEIGHT_WIDTH'(mag_scaled);
        end
    end

    // Frame FSM, read issue, peak tracking and frame bookkeeping
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        pending_d   = pending_q;
        max_val_d   = max_val_q;
        max_bin_d   = max_bin_q;
        peak_bin_d  = peak_bin_q;
        peak_val_d  = peak_val_q;
        frame_cnt_d = frame_cnt_q;
        rd_issue    = 1'b0;
        frame_start = 1'b0;
        inflight_d  = 1'b0;
        rd_bin_d    = rd_bin_q;

        // Running max over beats entering the FIFO; strict '>' keeps the lowest bin on ties
        if (inflight_q && !dc_skip && (fft_data_out > max_val_q)) begin
            max_val_d = fft_data_out;
            max_bin_d = rd_bin_q;
        end

        // A request arriving mid-frame is remembered once; extra pulses are dropped
        if (fft_done && (state_q == ST_READ || state_q == ST_DRAIN)) begin
            pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (fft_done) begin
                    state_d     = ST_READ;
                    frame_start = 1'b1;
                end
            end
            ST_READ: begin
                rd_issue = credit_ok;
                if (rd_issue) begin
                    addr_d = addr_q + 1'b1;
                    if (addr_q == LAST_BIN) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (fifo_pop && m_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                peak_bin_d  = max_bin_q;
                peak_val_d  = max_val_q;
                frame_cnt_d = frame_cnt_q + 16'd1;
                pending_d   = 1'b0;
                if (pending_q || fft_done) begin
                    state_d     = ST_READ;
                    frame_start = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (frame_start) begin
            addr_d    = '0;
            max_val_d = '0;
            max_bin_d = '0;
        end

        if (rd_issue) begin
            inflight_d = 1'b1;
            rd_bin_d   = addr_q;
        end
    end

    // State registers; reset also discards any read still in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            inflight_q  <= 1'b0;
            rd_bin_q    <= '0;
            pending_q   <= 1'b0;
            max_val_q   <= '0;
            max_bin_q   <= '0;
            peak_bin_q  <= '0;
            peak_val_q  <= '0;
            frame_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            inflight_q  <= inflight_d;
            rd_bin_q    <= rd_bin_d;
            pending_q   <= pending_d;
            max_val_q   <= max_val_d;
            max_bin_q   <= max_bin_d;
            peak_bin_q  <= peak_bin_d;
            peak_val_q  <= peak_val_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    spectrum_skid_fifo #(
        .BIN_WIDTH    (ADDR_WIDTH),
        .HEIGHT_WIDTH (HEIGHT_WIDTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .in_vld     (inflight_q),
        .in_last    (rd_bin_q == LAST_BIN),
        .in_bin     (rd_bin_q),
        .in_height  (height),
        .out_vld    (m_valid),
        .out_rdy    (m_ready),
        .out_last   (m_last),
        .out_bin    (m_bin),
        .out_height (m_height),
        .count      (fifo_count)
    );

    assign fft_addr_out    = addr_q;
    assign fft_data_out_en = rd_issue;
    assign busy            = (state_q != ST_IDLE);
    assign peak_bin        = peak_bin_q;
    assign peak_val        = peak_val_q;
    assign frame_cnt       = frame_cnt_q;

endmodule
